// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions: sideband field widths, packed layout of the
// optional fields, and pack/unpack helpers for stored words.
package axis_pkg;

  localparam int AXIS_DATA_W = 40;
  localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
  localparam int AXIS_ID_W   = 4;
  localparam int AXIS_DEST_W = 4;
  localparam int AXIS_USER_W = 8;

`ifdef AXIS_EN_TSTRB
  localparam int TSTRB_W = AXIS_KEEP_W;
`else
  localparam int TSTRB_W = 0;
`endif
`ifdef AXIS_EN_TKEEP
  localparam int TKEEP_W = AXIS_KEEP_W;
`else
  localparam int TKEEP_W = 0;
`endif
`ifdef AXIS_EN_TLAST
  localparam int TLAST_W = 1;
`else
  localparam int TLAST_W = 0;
`endif
`ifdef AXIS_EN_TID
  localparam int TID_W = AXIS_ID_W;
`else
  localparam int TID_W = 0;
`endif
`ifdef AXIS_EN_TDEST
  localparam int TDEST_W = AXIS_DEST_W;
`else
  localparam int TDEST_W = 0;
`endif
`ifdef AXIS_EN_TUSER
  localparam int TUSER_W = AXIS_USER_W;
`else
  localparam int TUSER_W = 0;
`endif

  localparam int OFF_TSTRB = 0;
  localparam int OFF_TKEEP = OFF_TSTRB + TSTRB_W;
  localparam int OFF_TLAST = OFF_TKEEP + TKEEP_W;
  localparam int OFF_TID   = OFF_TLAST + TLAST_W;
  localparam int OFF_TDEST = OFF_TID + TID_W;
  localparam int OFF_TUSER = OFF_TDEST + TDEST_W;
  localparam int SB_W      = OFF_TUSER + TUSER_W;
  // One spare bit keeps the stored sideband legal when no field is enabled.
  localparam int SB_PW     = (SB_W > 0) ? SB_W : 1;

  typedef struct packed {
    logic [AXIS_KEEP_W-1:0] tstrb;
    logic [AXIS_KEEP_W-1:0] tkeep;
    logic                   tlast;
    logic [AXIS_ID_W-1:0]   tid;
    logic [AXIS_DEST_W-1:0] tdest;
    logic [AXIS_USER_W-1:0] tuser;
  } axis_sb_t;

  typedef logic [SB_PW-1:0] axis_sb_word_t;

  function automatic axis_sb_word_t axis_pack_sb(input axis_sb_t sb);
    axis_sb_word_t w;
    w = '0;
    if (TSTRB_W != 0) w |= axis_sb_word_t'(sb.tstrb) << OFF_TSTRB;
    if (TKEEP_W != 0) w |= axis_sb_word_t'(sb.tkeep) << OFF_TKEEP;
    if (TLAST_W != 0) w |= axis_sb_word_t'(sb.tlast) << OFF_TLAST;
    if (TID_W   != 0) w |= axis_sb_word_t'(sb.tid)   << OFF_TID;
    if (TDEST_W != 0) w |= axis_sb_word_t'(sb.tdest) << OFF_TDEST;
    if (TUSER_W != 0) w |= axis_sb_word_t'(sb.tuser) << OFF_TUSER;
    return w;
  endfunction

  function automatic axis_sb_t axis_unpack_sb(input axis_sb_word_t w);
    axis_sb_t sb;
    sb = '0;
    if (TSTRB_W != 0) sb.tstrb = AXIS_KEEP_W'(w >> OFF_TSTRB);
    if (TKEEP_W != 0) sb.tkeep = AXIS_KEEP_W'(w >> OFF_TKEEP);
    if (TLAST_W != 0) sb.tlast = 1'(w >> OFF_TLAST);
    if (TID_W   != 0) sb.tid   = AXIS_ID_W'(w >> OFF_TID);
    if (TDEST_W != 0) sb.tdest = AXIS_DEST_W'(w >> OFF_TDEST);
    if (TUSER_W != 0) sb.tuser = AXIS_USER_W'(w >> OFF_TUSER);
    return sb;
  endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle; optional fields are always present, the FIFO carries only
// those enabled in axis_pkg.
interface axis_if
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W
) ();
  logic                   tvalid;
  logic                   tready;
  logic [DATA_W-1:0]      tdata;
  logic [AXIS_KEEP_W-1:0] tstrb;
  logic [AXIS_KEEP_W-1:0] tkeep;
  logic                   tlast;
  logic [AXIS_ID_W-1:0]   tid;
  logic [AXIS_DEST_W-1:0] tdest;
  logic [AXIS_USER_W-1:0] tuser;

  modport s (input tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, output tready);
  modport m (output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, input tready);
endinterface

// File: rtl/axis_sync_fifo_ptr_ctrl.sv
// Pointer bookkeeping for a power-of-two FIFO: wrap-bit pointers, full/empty,
// handshake qualification, occupancy and high-watermark.
module fifo_ptr_ctrl #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wr_valid_i,
  input  logic          rd_ready_i,
  input  logic          max_clr_i,
  output logic          wr_ready_o,
  output logic          rd_valid_o,
  output logic          wr_en_o,
  output logic          rd_en_o,
  output logic [AW-1:0] wr_idx_o,
  output logic [AW-1:0] rd_idx_o,
  output logic [PW-1:0] level_o,
  output logic [PW-1:0] max_level_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] max_q, max_d;
  logic [PW-1:0] level_d;
  logic          full, empty;

  assign full  = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Both ready and valid come from registered state only, and are held low
  // in the reset cycle so nothing is accepted or emitted then.
  assign wr_ready_o = !full && !rst_i;
  assign rd_valid_o = !empty && !rst_i;
  assign wr_en_o    = wr_valid_i && wr_ready_o;
  assign rd_en_o    = rd_ready_i && rd_valid_o;

  assign wr_idx_o    = wr_ptr_q[AW-1:0];
  assign rd_idx_o    = rd_ptr_q[AW-1:0];
  assign level_o     = wr_ptr_q - rd_ptr_q;
  assign max_level_o = max_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(wr_en_o);
    rd_ptr_d = rd_ptr_q + PW'(rd_en_o);
    level_d  = wr_ptr_d - rd_ptr_d;
    max_d    = max_q;
    if (max_clr_i) begin
      max_d = level_d;
    end else if (level_d > max_q) begin
      max_d = level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      max_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      max_q    <= max_d;
    end
  end

endmodule

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through AXI-Stream FIFO in front of a router input port,
// with occupancy and high-watermark outputs.
module axis_sync_fifo
  import axis_pkg::*;
#(
  parameter  int AXIS_DATA_WIDTH = 40,
  parameter  int DEPTH           = 8,
  localparam int CNT_W           = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  axis_if.s                s_axis,
  axis_if.m                m_axis,
  output logic [CNT_W-1:0] level_o,
  output logic [CNT_W-1:0] max_level_o,
  input  logic             max_clr_i
);

  localparam int AW     = $clog2(DEPTH);
  localparam int WORD_W = AXIS_DATA_WIDTH + SB_PW;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic              wr_en, rd_en;
  logic [AW-1:0]     wr_idx, rd_idx;
  logic              s_ready, m_valid;
  axis_sb_t          sb_in, sb_out;
  logic [WORD_W-1:0] wr_word, rd_word;

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wr_valid_i  (s_axis.tvalid),
    .rd_ready_i  (m_axis.tready),
    .max_clr_i   (max_clr_i),
    .wr_ready_o  (s_ready),
    .rd_valid_o  (m_valid),
    .wr_en_o     (wr_en),
    .rd_en_o     (rd_en),
    .wr_idx_o    (wr_idx),
    .rd_idx_o    (rd_idx),
    .level_o     (level_o),
    .max_level_o (max_level_o)
  );

  always_comb begin
    sb_in       = '0;
    sb_in.tstrb = s_axis.tstrb;
    sb_in.tkeep = s_axis.tkeep;
    sb_in.tlast = s_axis.tlast;
    sb_in.tid   = s_axis.tid;
    sb_in.tdest = s_axis.tdest;
    sb_in.tuser = s_axis.tuser;
    wr_word     = {s_axis.tdata, axis_pack_sb(sb_in)};
  end

  // Writes are gated by the handshake, so idle-bus X never reaches storage.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_word;
    end
  end

  assign rd_word = mem_q[rd_idx];
  assign sb_out  = axis_unpack_sb(rd_word[SB_PW-1:0]);

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = m_valid;
  assign m_axis.tdata  = rd_word[WORD_W-1 -: AXIS_DATA_WIDTH];
  assign m_axis.tstrb  = sb_out.tstrb;
  assign m_axis.tkeep  = sb_out.tkeep;
  assign m_axis.tlast  = sb_out.tlast;
  assign m_axis.tid    = sb_out.tid;
  assign m_axis.tdest  = sb_out.tdest;
  assign m_axis.tuser  = sb_out.tuser;

  logic unused_rd_en;
  assign unused_rd_en = rd_en;

endmodule

// File: doc/axis_sync_fifo.md
Name: axis_sync_fifo

Overview:
Single-clock AXI-Stream FIFO placed directly upstream of a NoC router input port: it accepts a stream on an axis_if slave modport and presents it unchanged on an axis_if master modport. It absorbs router back-pressure, decouples producer timing from the router, and reports occupancy plus a high-watermark for the PMU counters.

Parameters:
AXIS_DATA_WIDTH, 40, TDATA width; must match both attached axis_if instances.
DEPTH, 8, number of entries; power of two, at least 2.
CNT_W, $clog2(DEPTH)+1, width of the level outputs; derived, not overridden.

Ports:
clk_i  in  1  clock; all state changes on the rising edge.
rst_i  in  1  reset; synchronous and active-high.
s_axis  axis_if.s  -  input stream (TVALID, TREADY, TDATA, plus every optional field enabled by defines).
m_axis  axis_if.m  -  output stream, same field set as s_axis.
level_o  out  CNT_W  current number of stored beats (0..DEPTH).
max_level_o  out  CNT_W  highest level_o since the last reset or clear.
max_clr_i  in  1  synchronous clear of max_level_o.

Behaviour:
- Stored word = TDATA concatenated with every enabled optional field (TSTRB/TKEEP/TLAST/TID/TDEST/TUSER). Field layout comes from the shared package.
- Storage: DEPTH-entry array. wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits, with the MSB used as a wrap bit.
  - full when the pointers differ only in the MSB; empty when the pointers are equal.
  - Pointers wrap naturally modulo 2*DEPTH.
- Write: occurs when s_axis.TVALID && s_axis.TREADY. s_axis.TREADY = !full && !rst_i. It depends only on registered state; no combinational path from m_axis.TREADY.
- Read: occurs when m_axis.TVALID && m_axis.TREADY. m_axis.TVALID = !empty. m_axis data is the array entry at rd_ptr (first-word fall-through).
- Latency: a beat accepted in cycle N is visible on m_axis in cycle N+1. There is no same-cycle bypass when empty.
- Full with a simultaneous read: the write is refused that cycle (TREADY stays 0). TREADY rises the cycle after the read.
- Empty with a simultaneous write: only the write happens; TVALID rises the next cycle.
- Neither full nor empty, both handshakes in one cycle: level_o unchanged, both pointers advance.
- level_o = wr_ptr - rd_ptr, computed in CNT_W bits; always 0..DEPTH.
- max_level_o: registered.
  - Updates to the next-cycle level when that exceeds it.
  - max_clr_i loads the next-cycle level (not 0). max_clr_i wins over the update.
- AXI-Stream rule: once m_axis.TVALID is 1, it and the data hold stable until accepted. This holds inherently, because the head entry is never overwritten while not full.
- Reset values: wr_ptr=0, rd_ptr=0, level_o=0, max_level_o=0, m_axis.TVALID=0, s_axis.TREADY=0 during reset.
  - The array is not reset; its contents are don't-care.
- Reset mid-operation: all stored beats are discarded and no beat is emitted in the reset cycle. TREADY=1 on the first cycle after rst_i falls.
- Unknown/X on s_axis data while TVALID=0 must not propagate to state.

Decomposition:
- Shared package axis_pkg: localparam for the packed sideband width per enabled define, and pack/unpack functions for the stored word. The future upstream and downstream AXIS blocks reuse these.
- One natural sub-module, fifo_ptr_ctrl: pointer registers, full/empty, level, watermark. Width-agnostic, parameterized by DEPTH.
- The storage array stays in the top.

Test Plan:
- Reset, then drive 3 beats 0x01,0x02,0x03 with m_axis.TREADY=1 -> each appears one cycle after acceptance, in order; level_o peaks at 1; max_level_o=1.
- Fill with DEPTH=8 beats (0x10..0x17) while m_axis.TREADY=0 -> TREADY=0 after the 8th beat; level_o=8; max_level_o=8; m_axis holds 0x10 stable.
- While full, assert m_axis.TREADY for one cycle with s_axis.TVALID=1 -> 0x10 is read, the write is refused that cycle, TREADY=1 next cycle; a beat 0x18 written then lands after 0x17.
- Random TVALID/TREADY at 50%, 1000 beats with an incrementing pattern -> scoreboard matches exactly, with no loss or duplication; pointer wrap is exercised at least 100 times; level_o never exceeds 8.
- Load 5 beats, pulse max_clr_i while level_o=5, then drain -> max_level_o=5 right after clear and stays 5 while draining; level_o reaches 0; TVALID=0.
- Load 4 beats, assert rst_i for 1 cycle mid-stream -> next cycle TVALID=0, level_o=0, max_level_o=0, TREADY=1; no stale beat ever appears on m_axis.
